pll_clk_enable_gen: RTL
=======================

// Module: pll_clk_enable_gen
// PURPOSE
//   Lock supervisor and multi-channel clock-enable generator. Runs in the rPLL output domain.
//   - Qualifies the PLL LOCK signal and sequences a system reset from it.
//   - Generates NUM_CH fractional-rate clock enables. Each enable comes from a phase accumulator.
//   - Lets downstream logic run at many derived rates from one PLL clock.
// PARAMETERS
//   NUM_CH              4    number of clock-enable channels (1..8)
//   ACC_W               16   accumulator / increment width; enable rate = incr / 2^ACC_W * f_clk
//   LOCK_STABLE_CYCLES  1024 consecutive synced-lock cycles required before release (>=2)
// PORTS
//   clk        in   1             PLL output clock; sole clock
//   rst_n      in   1             asynchronous, active-low reset
//   pll_lock   in   1             raw rPLL LOCK; asynchronous to clk
//   ch_incr    in   NUM_CH*ACC_W  per-channel increments; channel i = [i*ACC_W +: ACC_W]
//   cfg_load   in   1             1-cycle pulse; copies ch_incr into shadow registers
//   ch_en      in   NUM_CH        per-channel enable
//   locked     out  1             1 while FSM in RUN
//   sys_rst_n  out  1             downstream reset, active-low; 1 only in RUN
//   ce         out  NUM_CH        registered clock-enable pulses, 1 cycle wide
//   lock_lost  out  1             sticky flag: lock dropped while in RUN
//   lost_clr   in   1             clears lock_lost
// BEHAVIOUR
//   Reset (rst_n=0, async):
//   - state=WAIT_LOCK; sync FFs, stable counter, accumulators and shadow increments = 0.
//   - locked=0, sys_rst_n=0, ce=0, lock_lost=0.
//   Synchroniser:
//   - pll_lock passes through 2 FFs to give lock_s; no other logic uses pll_lock.
//   FSM:
//   - WAIT_LOCK: cnt=0. lock_s=1 -> STABLE, cnt=1.
//   - STABLE: lock_s=0 -> WAIT_LOCK (cnt cleared).
//     - lock_s=1 and cnt==LOCK_STABLE_CYCLES-1 -> RUN.
//     - otherwise cnt+1.
//   - RUN: lock_s=0 -> WAIT_LOCK and lock_lost<=1.
//   - locked and sys_rst_n are registered and equal (state==RUN).
//   Timing:
//   - pll_lock rises before edge k (sampled at edge k): lock_s is 1 after edge k+1.
//   - locked=1 after edge k+LOCK_STABLE_CYCLES+1.
//   - pll_lock falls before edge k: locked=0 after edge k+2.
//   - A lock glitch of any length >= 1 synced cycle restarts qualification from zero.
//   Shadow config:
//   - cfg_load=1 latches all of ch_incr; new values take effect from the next cycle.
//   - ch_incr changes without cfg_load are ignored.
//   - cfg_load is accepted in every state, including reset sequencing.
//   Accumulators (per channel i):
//   - If state==RUN and lock_s==1 and ch_en[i]: {carry, acc_i} <= acc_i + incr_i (ACC_W+1-bit sum), and ce[i] <= carry.
//   - Otherwise acc_i <= 0 and ce[i] <= 0.
//   - So ce is 0 whenever locked is 0 or in the cycle locked falls.
//   - Accumulator is not cleared by cfg_load; rate changes are phase-continuous.
//   - incr=0 -> ce never asserts. Max rate is (2^ACC_W-1)/2^ACC_W; ce is never continuously 1.
//   - Wrap-around is modulo 2^ACC_W; the pulse count over 2^ACC_W cycles is exactly incr.
//   - ch_en 1->0 clears the channel next edge. On re-enable the first ce comes after ceil(2^ACC_W/incr) cycles.
//   lock_lost:
//   - set on RUN->WAIT_LOCK; cleared by lost_clr; set wins when both occur in the same cycle.
//   Reset mid-operation: all state returns to reset values immediately, shadow increments included.
// TESTING (bench: LOCK_STABLE_CYCLES=16, ACC_W=8, NUM_CH=4)
//   1. rst_n=0 with pll_lock=1 and cfg_load pulsing -> locked=sys_rst_n=ce=lock_lost=0 throughout.
//   2. pll_lock=1 sampled at edge 10 -> locked and sys_rst_n rise after edge 27, not before.
//   3. pll_lock low for 1 cycle at STABLE cnt=8 -> locked rises 16 cycles after lock_s returns high.
//   4. Load incr0=64, incr1=85, incr2=0, incr3=255, all enabled, in RUN -> over 256 cycles ce0 gives 64 pulses (every 4th cycle), ce1 gives 85, ce2 gives 0, ce3 gives 255.
//   5. Drop pll_lock in RUN -> locked=0 two edges later, ce=0 same cycle, lock_lost=1; lost_clr on that edge -> lock_lost stays 1.
//   6. Change ch_incr without cfg_load -> ce spacing unchanged. Then pulse cfg_load with incr0 64->128 -> spacing goes 4->2 with no accumulator reset.

Source files
------------

// File: rtl/pll_clk_enable_gen.sv
// PLL lock supervisor with sequenced system reset, plus NUM_CH phase-accumulator
// clock-enable generators running in the PLL output clock domain.
module pll_clk_enable_gen #(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned ACC_W              = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_lock,
    input  logic [NUM_CH*ACC_W-1:0] ch_incr,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic                    locked,
    output logic                    sys_rst_n,
    output logic [NUM_CH-1:0]       ce,
    output logic                    lock_lost,
    input  logic                    lost_clr
);

    localparam int unsigned CNT_W = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CNT_W-1:0]              r_cnt;
    logic [CNT_W-1:0]              w_cnt_nxt;
    logic                          w_lost_set;

    logic                          r_sync_meta;
    logic                          r_lock_s;

    logic                          r_locked;
    logic                          r_sys_rst_n;
    logic                          r_lock_lost;

    logic [NUM_CH-1:0][ACC_W-1:0]  r_incr;
    logic [NUM_CH-1:0][ACC_W-1:0]  r_acc;
    logic [NUM_CH-1:0][ACC_W:0]    w_sum;
    logic [NUM_CH-1:0]             r_ce;
    logic                          w_run_ok;

    // Two-flop synchroniser: the only consumer of the raw pll_lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= pll_lock;
            r_lock_s    <= r_sync_meta;
        end
    end

    // Lock qualification state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Any deasserted synced-lock cycle restarts qualification from zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lost_set  = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_lost_set  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Status outputs track the next state so they change on the same edge as r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked    <= 1'b0;
            r_sys_rst_n <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_locked    <= (w_state_nxt == S_RUN);
            r_sys_rst_n <= (w_state_nxt == S_RUN);
            if (w_lost_set) begin
                r_lock_lost <= 1'b1;
            end else if (lost_clr) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

    // Shadow increments; loading never disturbs accumulator phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_incr <= '0;
        end else if (cfg_load) begin
            r_incr <= ch_incr;
        end
    end

    assign w_run_ok = (r_state == S_RUN) && r_lock_s;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_incr[i]};
        end
    end

    // Carry out of each accumulator becomes that channel's enable pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ce  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (w_run_ok && ch_en[i]) begin
                    r_acc[i] <= w_sum[i][ACC_W-1:0];
                    r_ce[i]  <= w_sum[i][ACC_W];
                end else begin
                    r_acc[i] <= '0;
                    r_ce[i]  <= 1'b0;
                end
            end
        end
    end

    assign locked    = r_locked;
    assign sys_rst_n = r_sys_rst_n;
    assign lock_lost = r_lock_lost;
    assign ce        = r_ce;

endmodule
